game_timer_bcd: RTL and testbench
=================================

# game_timer_bcd

Parametrised BCD game timer that succeeds the fixed 1:59 countdown clock. It generates a 1 Hz tick from the system clock and drives four BCD digits (MM:SS) that count down or up, selected at run time. It accepts a runtime preset load and flags expiry with a sticky level and a one-cycle pulse. It sits between the game FSM (enable/load/mode) and the seven-segment scoreboard driver.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; the prescaler divides by this value to produce one tick. Minimum 2.
- START_MIN, 1, reset value of minutes, 0–99.
- START_SEC, 59, reset value of seconds, 0–59.
- WARN_SEC, 10, low-time warning threshold in seconds, 0–59. Used only with TIMER_WARN_EN.

Ports:
- clk_100MHz  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level input; high runs the timer, low pauses it.
- mode  in  1  0 = count down, 1 = count up.
- load  in  1  one-cycle preset strobe.
- load_value  in  16  preset digits {min_10s, min_1s, sec_10s, sec_1s}, 4 bits each.
- tick_1Hz  out  1  one-cycle pulse per elapsed second.
- sec_1s, sec_10s, min_1s, min_10s  out  4 each  BCD digits.
- expired  out  1  sticky end-of-time flag.
- expire_pulse  out  1  one-cycle pulse, asserted on the cycle `expired` rises.
- warn  out  1  low-time warning (present only with TIMER_WARN_EN).

## Operation
- Reset values: prescaler count 0, tick_1Hz 0, digits = START_MIN/START_SEC split into BCD, expired 0, expire_pulse 0, warn 0.
- The timer is running when `enable && !expired && !load`. The prescaler counter, width $clog2(CLK_HZ), advances only while running.
- While paused, the prescaler holds its count (it is not cleared) and tick_1Hz is 0.
- When the counter is at CLK_HZ-1 and the timer is running, the counter wraps to 0 and tick_1Hz is registered 1 for one cycle.
- Digits update on the edge where tick_1Hz==1 && enable && !expired. If enable drops in the same cycle as the tick, that tick is dropped.
- Down mode:
  - sec_1s decrements.
  - At 0, sec_1s goes to 9 and sec_10s decrements.
  - When sec_10s is also 0, sec_10s goes to 5 and min_1s decrements.
  - When min_1s is 0, min_1s goes to 9 and min_10s decrements.
  - The update that produces 00:00 also sets expired and pulses expire_pulse.
  - A tick taken while already at 00:00 (e.g. after loading 00:00) leaves the digits unchanged and sets expired.
- Up mode:
  - Mirror increment: sec_1s 9→0 carries into sec_10s, sec_10s 5→0 carries into min_1s, min_1s 9→0 carries into min_10s.
  - Reaching 99:59 sets expired and pulses expire_pulse.
  - A tick taken at 99:59 leaves the digits unchanged and sets expired.
- Mode is sampled at each tick and may change mid-run. The next tick uses the new direction from the current digits.
- load:
  - Clamps each field of load_value into the digits: sec_10s >5 becomes 5; every other digit >9 becomes 9.
  - Clears the prescaler, expired, tick_1Hz and expire_pulse.
  - Load has priority over a simultaneous tick and over enable.
- Once set, expired holds until load or reset. No tick is generated while expired.
- Asynchronous reset_n assertion mid-count forces all reset values immediately. Release is synchronised by the system integrator.

## Timing
- First tick_1Hz rises CLK_HZ cycles after the first running cycle. Subsequent ticks follow every CLK_HZ running cycles.
- Digits, expired and expire_pulse change on the edge after the tick cycle, which is 1 cycle of latency from tick_1Hz.
- Load takes effect on the edge that samples load=1. Counting resumes CLK_HZ running cycles after the load cycle.
- Pause and resume preserve the sub-second phase. Total running time between ticks is always exactly CLK_HZ cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- TIMER_WARN_EN defined:
  - `warn` port exists as a registered output.
  - warn = 1 when mode==0 && !expired && minutes==00 && (10·sec_10s + sec_1s) ≤ WARN_SEC.
  - warn updates on the same edge as the digits and on load. Its reset value is 0.
- TIMER_WARN_EN undefined: the `warn` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset with CLK_HZ=10 and defaults → digits 0,1,5,9 (01:59), expired=0. With enable=1, tick_1Hz pulses on the 10th cycle and the digits read 01:58 one edge later.
- Load 0x0100, mode=0, one tick → digits read 00:59. Load 0x1000, one tick → digits read 09:59. Pause enable for 7 cycles mid-second → the next tick still arrives after exactly 10 running cycles.
- Load 0x0002, mode=0, two ticks → digits 00:00, expired=1, expire_pulse high for exactly 1 cycle. Twenty further cycles → no tick_1Hz and digits hold. Then load 0x0005 → expired=0.
- Load 0x9958, mode=1, one tick → 99:59 with expired=1. Load 0x0059, mode=1, one tick → 01:00.
- Load 0xFAFF → digits read 99:59 after clamping. Assert load in the same cycle as tick_1Hz → loaded value wins, no decrement, prescaler returns to 0.
- Drop reset_n between clock edges while counting → all outputs return to reset values immediately. With TIMER_WARN_EN and WARN_SEC=10: load 0x0011, one tick → 00:10 with warn=1; switch to mode=1 and take one tick → warn=0.

Source files
------------

// File: rtl/game_timer_bcd.sv
// ============================================================================
// game_timer_bcd
// ----------------------------------------------------------------------------
// BCD game timer showing MM:SS on four digits. A prescaler turns the system
// clock into a one-cycle tick every CLK_HZ running cycles. Each accepted tick
// moves the digits one second down (mode=0) or up (mode=1). The game FSM can
// preset the digits with a one-cycle load strobe. When the digits reach the
// end of their range (00:00 counting down, 99:59 counting up) the timer sets a
// sticky expired flag and emits a one-cycle expire_pulse.
//
// Parameters
//   CLK_HZ     input clock frequency; prescaler divide ratio (>= 2)
//   START_MIN  reset value of the minutes, 0..99
//   START_SEC  reset value of the seconds, 0..59
//   WARN_SEC   low-time warning threshold in seconds, 0..59
//
// Ports
//   clk_100MHz    in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   high = run, low = pause (sub-second phase is kept)
//   mode          in   0 = count down, 1 = count up (sampled at every tick)
//   load          in   one-cycle preset strobe, beats tick and enable
//   load_value    in   {min_10s, min_1s, sec_10s, sec_1s}, clamped on load
//   tick_1Hz      out  one-cycle pulse per elapsed second
//   sec_1s .. min_10s out  BCD digits
//   expired       out  sticky end-of-time flag, cleared by load/reset
//   expire_pulse  out  one-cycle pulse on the cycle expired rises
//   warn          out  low-time warning (only with TIMER_WARN_EN)
//
// Build option
//   TIMER_WARN_EN  when defined, adds the registered warn output.
//
// All outputs come straight from flops.
// ============================================================================
module game_timer_bcd #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int START_MIN = 1,
   parameter int START_SEC = 59,
   parameter int WARN_SEC  = 10
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        mode,
   input  logic        load,
   input  logic [15:0] load_value,
   output logic        tick_1Hz,
   output logic [3:0]  sec_1s,
   output logic [3:0]  sec_10s,
   output logic [3:0]  min_1s,
   output logic [3:0]  min_10s,
   output logic        expired,
   output logic        expire_pulse
`ifdef TIMER_WARN_EN
   ,
   output logic        warn
`endif
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int              PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRE_LAST   = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]   PRE_ONE    = PW'(1);
   localparam logic [15:0]     RESET_DIGITS = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                               4'(START_SEC / 10), 4'(START_SEC % 10)};
   localparam logic [15:0]     TOP_DIGITS = 16'h9959;

   // Parameter ranges are checked while elaborating so a bad instance never
   // produces a silently wrong reset value or divide ratio.
   if (CLK_HZ < 2 || START_MIN < 0 || START_MIN > 99 || START_SEC < 0 ||
       START_SEC > 59 || WARN_SEC < 0 || WARN_SEC > 59) begin : g_bad_params
      $error("game_timer_bcd: parameter out of range");
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PW-1:0]    pre_cnt_reg;
   logic             tick_reg;
   logic             expired_reg;
   logic             pulse_reg;
   // Packed as {min_10s, min_1s, sec_10s, sec_1s}, same order as load_value.
   logic [3:0][3:0]  digit_reg;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [3:0][3:0]  load_digit;   // clamped preset
   logic [3:0][3:0]  step_digit;   // digits one second later in current mode
   logic [3:0]       at_lim;       // digit sits at its wrap point for this mode
   logic [3:0]       ripple;       // borrow/carry reaches this digit
   logic             running;
   logic             digit_update;
   logic             at_end;
   logic             step_end;

   assign running      = enable && !expired_reg && !load;
   // The tick is a registered pulse; digits only move if the timer is still
   // enabled on the following edge, so a tick coinciding with a pause is lost.
   assign digit_update = tick_reg && enable && !expired_reg;

   // One slice per digit. Digit 1 (sec_10s) wraps at 5, the rest at 9. The
   // carry/borrow into a digit is the AND of the wrap conditions of all less
   // significant digits, so no signal depends on itself.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] DMAX = (gi == 1) ? 4'd5 : 4'd9;

         assign load_digit[gi] = (load_value[gi*4 +: 4] > DMAX) ? DMAX
                                                                 : load_value[gi*4 +: 4];

         assign at_lim[gi] = mode ? (digit_reg[gi] == DMAX) : (digit_reg[gi] == 4'd0);

         if (gi == 0) begin : g_lsd
            assign ripple[gi] = 1'b1;
         end else begin : g_upper
            assign ripple[gi] = &at_lim[gi-1:0];
         end

         assign step_digit[gi] = !ripple[gi] ? digit_reg[gi]
                               : mode        ? (at_lim[gi] ? 4'd0 : digit_reg[gi] + 4'd1)
                                             : (at_lim[gi] ? DMAX : digit_reg[gi] - 4'd1);
      end
   endgenerate

   // Already at the end of the range: a tick must not wrap the display.
   assign at_end   = &at_lim;
   // The step lands exactly on the end of the range.
   assign step_end = (step_digit == (mode ? TOP_DIGITS : 16'h0000));

   // ------------------------------------------------------------------------
   // Prescaler, digits and expiry
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_reg <= '0;
         tick_reg    <= 1'b0;
         expired_reg <= 1'b0;
         pulse_reg   <= 1'b0;
         digit_reg   <= RESET_DIGITS;
      end else if (load) begin
         // Load restarts the second from zero and discards any pending tick.
         pre_cnt_reg <= '0;
         tick_reg    <= 1'b0;
         expired_reg <= 1'b0;
         pulse_reg   <= 1'b0;
         digit_reg   <= load_digit;
      end else begin
         tick_reg  <= 1'b0;
         pulse_reg <= 1'b0;

         // Paused: hold the count so the sub-second phase survives.
         if (running) begin
            if (pre_cnt_reg == PRE_LAST) begin
               pre_cnt_reg <= '0;
               tick_reg    <= 1'b1;
            end else begin
               pre_cnt_reg <= pre_cnt_reg + PRE_ONE;
            end
         end

         if (digit_update) begin
            if (at_end) begin
               expired_reg <= 1'b1;
               pulse_reg   <= 1'b1;
            end else begin
               digit_reg <= step_digit;
               if (step_end) begin
                  expired_reg <= 1'b1;
                  pulse_reg   <= 1'b1;
               end
            end
         end
      end
   end

   assign tick_1Hz     = tick_reg;
   assign expired      = expired_reg;
   assign expire_pulse = pulse_reg;
   assign sec_1s       = digit_reg[0];
   assign sec_10s      = digit_reg[1];
   assign min_1s       = digit_reg[2];
   assign min_10s      = digit_reg[3];

   // ------------------------------------------------------------------------
   // Low-time warning
   // ------------------------------------------------------------------------
`ifdef TIMER_WARN_EN
   logic warn_reg;
   logic warn_load;
   logic warn_step;

   function automatic logic low_time(input logic [3:0][3:0] d);
      return (d[3] == 4'd0) && (d[2] == 4'd0) &&
             ((int'(d[1]) * 10 + int'(d[0])) <= WARN_SEC);
   endfunction

   // Warn follows the values the digits/expired flag take on the same edge,
   // so it never lags the display. Counting up never warns.
   assign warn_load = !mode && low_time(load_digit);
   assign warn_step = !mode && !(at_end || step_end) && low_time(step_digit);

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         warn_reg <= 1'b0;
      end else if (load) begin
         warn_reg <= warn_load;
      end else if (digit_update) begin
         warn_reg <= warn_step;
      end
   end

   assign warn = warn_reg;
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// ============================================================================
// tb_game_timer_bcd
// Self-checking bench for game_timer_bcd with CLK_HZ = 10. A reference model
// keeps the remaining/elapsed time as a plain count of seconds and the
// sub-second phase as a count of running cycles; digits are derived from it
// by division. Directed scenarios also check hand-computed constants.
// ============================================================================
module tb_game_timer_bcd;

   localparam int CLK_HZ   = 10;
   localparam int WARN_SEC = 10;
   localparam int MAXT     = 99 * 60 + 59;
   localparam int START_T  = 1 * 60 + 59;

   logic        clk_100MHz = 1'b0;
   logic        reset_n    = 1'b0;
   logic        enable     = 1'b0;
   logic        mode       = 1'b0;
   logic        load       = 1'b0;
   logic [15:0] load_value = 16'h0000;
   logic        tick_1Hz;
   logic [3:0]  sec_1s, sec_10s, min_1s, min_10s;
   logic        expired;
   logic        expire_pulse;
   logic        warn_sig;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_cnt;
   int m_total;
   bit m_tick, m_exp, m_pulse, m_warn;

   game_timer_bcd #(
      .CLK_HZ   (CLK_HZ),
      .START_MIN(1),
      .START_SEC(59),
      .WARN_SEC (WARN_SEC)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset_n     (reset_n),
      .enable      (enable),
      .mode        (mode),
      .load        (load),
      .load_value  (load_value),
      .tick_1Hz    (tick_1Hz),
      .sec_1s      (sec_1s),
      .sec_10s     (sec_10s),
      .min_1s      (min_1s),
      .min_10s     (min_10s),
      .expired     (expired),
      .expire_pulse(expire_pulse)
`ifdef TIMER_WARN_EN
      ,
      .warn        (warn_sig)
`endif
   );

`ifndef TIMER_WARN_EN
   assign warn_sig = 1'b0;
`endif

   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic int clamp_total(input logic [15:0] v);
      int m10, m1, s10, s1;
      m10 = (v[15:12] > 9) ? 9 : int'(v[15:12]);
      m1  = (v[11:8]  > 9) ? 9 : int'(v[11:8]);
      s10 = (v[7:4]   > 5) ? 5 : int'(v[7:4]);
      s1  = (v[3:0]   > 9) ? 9 : int'(v[3:0]);
      return (m10 * 10 + m1) * 60 + s10 * 10 + s1;
   endfunction

   // Minutes == 0 and seconds <= WARN_SEC is the same as total <= WARN_SEC.
   function automatic bit warn_of(input int total, input bit md, input bit ex);
      return !md && !ex && (total <= WARN_SEC);
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_total = START_T;
      m_tick  = 0;
      m_exp   = 0;
      m_pulse = 0;
      m_warn  = 0;
   endtask

   task automatic model_step(input bit en, input bit md, input bit ld, input logic [15:0] lv);
      bit nt;
      bit upd;
      nt = 0;
      if (ld) begin
         m_cnt   = 0;
         m_tick  = 0;
         m_total = clamp_total(lv);
         m_exp   = 0;
         m_pulse = 0;
         m_warn  = warn_of(m_total, md, 0);
      end else begin
         upd = m_tick && en && !m_exp;
         if (en && !m_exp) begin
            m_cnt++;
            if (m_cnt == CLK_HZ) begin
               m_cnt = 0;
               nt    = 1;
            end
         end
         m_pulse = 0;
         if (upd) begin
            if (md) begin
               if (m_total < MAXT) m_total++;
            end else begin
               if (m_total > 0) m_total--;
            end
            if (m_total == (md ? MAXT : 0)) begin
               m_exp   = 1;
               m_pulse = 1;
            end
            m_warn = warn_of(m_total, md, m_exp);
         end
         m_tick = nt;
      end
   endtask

   function automatic logic [19:0] model_vec();
      int m, s;
      logic w;
      m = m_total / 60;
      s = m_total % 60;
`ifdef TIMER_WARN_EN
      w = m_warn;
`else
      w = 1'b0;
`endif
      return {m_tick, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), m_exp, m_pulse, w};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {tick_1Hz, min_10s, min_1s, sec_10s, sec_1s, expired, expire_pulse, warn_sig};
   endfunction

   function automatic logic [15:0] digits();
      return {min_10s, min_1s, sec_10s, sec_1s};
   endfunction

   // One clock: drive inputs, take the edge, advance the model, settle.
   task automatic cycle(input bit en, input bit md, input bit ld, input logic [15:0] lv);
      enable     = en;
      mode       = md;
      load       = ld;
      load_value = lv;
      @(posedge clk_100MHz);
      model_step(en, md, ld, lv);
      #1;
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_100MHz);
      vectors++;
      if (dut_vec() !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_model: dut=%h expected=%h", dut_vec(), model_vec());
      end
      vectors++;
      if (digits() !== 16'h0159 || expired !== 1'b0 || tick_1Hz !== 1'b0 || expire_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values: digits=%h exp=%b tick=%b pulse=%b expected 0159/0/0/0",
                  digits(), expired, tick_1Hz, expire_pulse);
      end
      reset_n = 1'b1;
      $display("test_reset: digits=%h expired=%b", digits(), expired);
   endtask

   task automatic test_first_tick();
      for (int i = 1; i <= 11; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL first_tick_model cyc %0d: dut=%h expected=%h", i, dut_vec(), model_vec());
         end
         vectors++;
         if (tick_1Hz !== (i == 10)) begin
            miscompares++;
            $display("FAIL first_tick_pos cyc %0d: tick=%b expected=%b", i, tick_1Hz, (i == 10));
         end
      end
      vectors++;
      if (digits() !== 16'h0158) begin
         miscompares++;
         $display("FAIL first_tick_digits: got %h expected 0158", digits());
      end
      $display("test_first_tick: digits=%h", digits());
   endtask

   task automatic test_load_carry();
      logic [15:0] lv [2];
      logic [15:0] exp_d [2];
      lv[0] = 16'h0100; exp_d[0] = 16'h0059;
      lv[1] = 16'h1000; exp_d[1] = 16'h0959;
      for (int k = 0; k < 2; k++) begin
         cycle(0, 0, 1, lv[k]);
         for (int i = 0; i < 11; i++) begin
            cycle(1, 0, 0, 16'h0000);
            vectors++;
            if (dut_vec() !== model_vec()) begin
               miscompares++;
               $display("FAIL load_carry_model: dut=%h expected=%h", dut_vec(), model_vec());
            end
         end
         vectors++;
         if (digits() !== exp_d[k]) begin
            miscompares++;
            $display("FAIL load_carry_digits: load %h got %h expected %h", lv[k], digits(), exp_d[k]);
         end
         $display("test_load_carry: load=%h digits=%h", lv[k], digits());
      end
   endtask

   task automatic test_pause();
      cycle(1, 0, 1, 16'h0030);
      repeat (4) cycle(1, 0, 0, 16'h0000);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 0, 16'h0000);
         vectors++;
         if (tick_1Hz !== 1'b0 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL pause_hold: dut=%h expected=%h", dut_vec(), model_vec());
         end
      end
      for (int i = 1; i <= 6; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (tick_1Hz !== (i == 6)) begin
            miscompares++;
            $display("FAIL pause_phase cyc %0d: tick=%b expected=%b", i, tick_1Hz, (i == 6));
         end
      end
      cycle(1, 0, 0, 16'h0000);
      vectors++;
      if (digits() !== 16'h0029) begin
         miscompares++;
         $display("FAIL pause_digits: got %h expected 0029", digits());
      end
      $display("test_pause: digits=%h", digits());
   endtask

   task automatic test_expire_down();
      cycle(1, 0, 1, 16'h0002);
      for (int i = 0; i < 21; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL expire_model: dut=%h expected=%h", dut_vec(), model_vec());
         end
      end
      vectors++;
      if (digits() !== 16'h0000 || expired !== 1'b1 || expire_pulse !== 1'b1) begin
         miscompares++;
         $display("FAIL expire_set: digits=%h exp=%b pulse=%b expected 0000/1/1",
                  digits(), expired, expire_pulse);
      end
      cycle(1, 0, 0, 16'h0000);
      vectors++;
      if (expire_pulse !== 1'b0 || expired !== 1'b1) begin
         miscompares++;
         $display("FAIL expire_pulse_width: pulse=%b exp=%b expected 0/1", expire_pulse, expired);
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (tick_1Hz !== 1'b0 || digits() !== 16'h0000 || expired !== 1'b1) begin
            miscompares++;
            $display("FAIL expire_hold: tick=%b digits=%h exp=%b", tick_1Hz, digits(), expired);
         end
      end
      cycle(1, 0, 1, 16'h0005);
      vectors++;
      if (expired !== 1'b0 || digits() !== 16'h0005) begin
         miscompares++;
         $display("FAIL expire_clear: exp=%b digits=%h expected 0/0005", expired, digits());
      end
      $display("test_expire_down: digits=%h expired=%b", digits(), expired);
   endtask

   task automatic test_up();
      logic [15:0] lv [2];
      logic [15:0] exp_d [2];
      logic        exp_x [2];
      lv[0] = 16'h9958; exp_d[0] = 16'h9959; exp_x[0] = 1'b1;
      lv[1] = 16'h0059; exp_d[1] = 16'h0100; exp_x[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle(1, 1, 1, lv[k]);
         for (int i = 0; i < 11; i++) begin
            cycle(1, 1, 0, 16'h0000);
            vectors++;
            if (dut_vec() !== model_vec()) begin
               miscompares++;
               $display("FAIL up_model: dut=%h expected=%h", dut_vec(), model_vec());
            end
         end
         vectors++;
         if (digits() !== exp_d[k] || expired !== exp_x[k]) begin
            miscompares++;
            $display("FAIL up_digits: load %h got %h/%b expected %h/%b",
                     lv[k], digits(), expired, exp_d[k], exp_x[k]);
         end
         $display("test_up: load=%h digits=%h expired=%b", lv[k], digits(), expired);
      end
   endtask

   task automatic test_clamp_load_tick();
      cycle(0, 0, 1, 16'hFAFF);
      vectors++;
      if (digits() !== 16'h9959 || expired !== 1'b0) begin
         miscompares++;
         $display("FAIL clamp: got %h/%b expected 9959/0", digits(), expired);
      end
      cycle(1, 0, 1, 16'h0030);
      repeat (10) cycle(1, 0, 0, 16'h0000);
      vectors++;
      if (tick_1Hz !== 1'b1) begin
         miscompares++;
         $display("FAIL load_tick_setup: tick=%b expected 1", tick_1Hz);
      end
      cycle(1, 0, 1, 16'h0045);
      vectors++;
      if (digits() !== 16'h0045 || tick_1Hz !== 1'b0) begin
         miscompares++;
         $display("FAIL load_beats_tick: digits=%h tick=%b expected 0045/0", digits(), tick_1Hz);
      end
      for (int i = 1; i <= 11; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (tick_1Hz !== (i == 10) || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL load_restart cyc %0d: dut=%h expected=%h", i, dut_vec(), model_vec());
         end
      end
      vectors++;
      if (digits() !== 16'h0044) begin
         miscompares++;
         $display("FAIL load_restart_digits: got %h expected 0044", digits());
      end
      $display("test_clamp_load_tick: digits=%h", digits());
   endtask

`ifdef TIMER_WARN_EN
   task automatic test_warn();
      cycle(1, 0, 1, 16'h0011);
      vectors++;
      if (warn_sig !== 1'b0) begin
         miscompares++;
         $display("FAIL warn_after_load: warn=%b expected 0", warn_sig);
      end
      repeat (11) cycle(1, 0, 0, 16'h0000);
      vectors++;
      if (digits() !== 16'h0010 || warn_sig !== 1'b1) begin
         miscompares++;
         $display("FAIL warn_set: digits=%h warn=%b expected 0010/1", digits(), warn_sig);
      end
      repeat (11) cycle(1, 1, 0, 16'h0000);
      vectors++;
      if (digits() !== 16'h0011 || warn_sig !== 1'b0) begin
         miscompares++;
         $display("FAIL warn_up_clear: digits=%h warn=%b expected 0011/0", digits(), warn_sig);
      end
      $display("test_warn: digits=%h warn=%b", digits(), warn_sig);
   endtask
`endif

   task automatic test_async_reset();
      cycle(1, 0, 1, 16'h0030);
      repeat (5) cycle(1, 0, 0, 16'h0000);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (dut_vec() !== model_vec() || digits() !== 16'h0159) begin
         miscompares++;
         $display("FAIL async_reset: dut=%h expected=%h", dut_vec(), model_vec());
      end
      @(posedge clk_100MHz);
      #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
         miscompares++;
         $display("FAIL async_reset_hold: dut=%h expected=%h", dut_vec(), model_vec());
      end
      reset_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cycle(1, 0, 0, 16'h0000);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL after_reset_model: dut=%h expected=%h", dut_vec(), model_vec());
         end
      end
      vectors++;
      if (digits() !== 16'h0158) begin
         miscompares++;
         $display("FAIL after_reset_digits: got %h expected 0158", digits());
      end
      $display("test_async_reset: digits=%h", digits());
   endtask

   task automatic test_random();
      bit en, md, ld;
      logic [15:0] lv;
      int n_tick, n_exp;
      md = 0;
      n_tick = 0;
      n_exp = 0;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) md = ~md;
         ld = ($urandom_range(0, 149) == 0);
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom);
            1:       lv = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            2:       lv = {8'h99, 4'h5, 4'($urandom_range(5, 9))};
            default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         endcase
         cycle(en, md, ld, lv);
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL random cyc %0d: dut=%h expected=%h", i, dut_vec(), model_vec());
         end
         if (m_tick) n_tick++;
         if (m_pulse) n_exp++;
      end
      $display("test_random: 3000 cycles, %0d ticks, %0d expiries", n_tick, n_exp);
   endtask

   initial begin
      test_reset();
      test_first_tick();
      test_load_carry();
      test_pause();
      test_expire_down();
      test_up();
      test_clamp_load_tick();
`ifdef TIMER_WARN_EN
      test_warn();
`endif
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
